multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_ctrl_pkg.sv | 51 +++++
 rtl/imm_src_decoder.sv | 22 ++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes and the datapath select/ALUOp/ResultSrc/ImmSrc codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BEQ,
      JAL,
      LUI
   } state_t;

   localparam logic [6:0] OPC_LW    = 7'b0000011;
   localparam logic [6:0] OPC_SW    = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;
   localparam logic [6:0] OPC_BEQ   = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMM       = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate format select decoded directly from the opcode.
module imm_src_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opc,
   output logic [2:0] ImmSrc
);

   // opcode to immediate format; unknown opcodes fall back to I-type
   always_comb begin
      ImmSrc = IMM_I;
      case (opc)
         OPC_LW, OPC_ITYPE: ImmSrc = IMM_I;
         OPC_SW:            ImmSrc = IMM_S;
         OPC_BEQ:           ImmSrc = IMM_B;
         OPC_JAL:           ImmSrc = IMM_J;
         OPC_LUI:           ImmSrc = IMM_U;
         default:           ImmSrc = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller: Moore FSM driving datapath enables/selects.
// Optional memory wait states with timeout are enabled by defining MEM_WAIT_EN.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opc,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCUpdate,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       PCWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       illegal,
   output logic       mem_err
);

   state_t state, state_next;
   logic   ready;
   logic   timeout;

`ifdef MEM_WAIT_EN
   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;

   assign waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign ready   = mem_ready;
   assign timeout = waiting && !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT));
   assign mem_err = timeout;

   // count stalled cycles in a wait state; cleared on progress or timeout
   always_ff @(posedge clk) begin
      if (reset)
         wait_cnt <= '0;
      else if (waiting && !mem_ready && !timeout)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end
`else
   localparam int unsigned unused_timeout = MEM_TIMEOUT;
   logic unused_mem_ready;

   assign unused_mem_ready = mem_ready;
   assign ready            = 1'b1;
   assign timeout          = 1'b0;
   assign mem_err          = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= FETCH;
      else
         state <= state_next;
   end

   // next-state and per-state datapath controls
   always_comb begin
      state_next = state;
      PCUpdate   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_REG;
      ALUOp      = ALUOP_ADD;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            IRWrite   = ready;
            PCUpdate  = ready;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALUOP_ADD;
            ResultSrc = RES_ALURESULT;
            if (timeout)
               state_next = FETCH;
            else if (ready)
               state_next = DECODE;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
            case (opc)
               OPC_LW, OPC_SW: state_next = MEMADR;
               OPC_RTYPE:      state_next = EXECUTER;
               OPC_ITYPE:      state_next = EXECUTEI;
               OPC_BEQ:        state_next = BEQ;
               OPC_JAL:        state_next = JAL;
               OPC_LUI:        state_next = LUI;
               default: begin
                  illegal    = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALUOP_ADD;
            state_next = (opc == OPC_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            ResultSrc = RES_ALUOUT;
            AdrSrc    = 1'b1;
            if (timeout)
               state_next = FETCH;
            else if (ready)
               state_next = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            ResultSrc = RES_ALUOUT;
            AdrSrc    = 1'b1;
            MemWrite  = ready;
            if (timeout || ready)
               state_next = FETCH;
         end
         EXECUTER: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = SRCB_REG;
            ALUOp      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALUOP_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            ResultSrc  = RES_ALUOUT;
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = SRCB_REG;
            ALUOp      = ALUOP_SUB;
            ResultSrc  = RES_ALUOUT;
            state_next = FETCH;
         end
         JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            ALUOp      = ALUOP_ADD;
            ResultSrc  = RES_ALUOUT;
            PCUpdate   = 1'b1;
            state_next = ALUWB;
         end
         LUI: begin
            ResultSrc  = RES_IMM;
            RegWrite   = 1'b1;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

   assign PCWrite = PCUpdate | ((state == BEQ) & zero);

   imm_src_decoder u_imm_src_decoder (
      .opc    (opc),
      .ImmSrc (ImmSrc)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Build with MEM_WAIT_EN defined to exercise the wait-state/timeout scenarios.
module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [6:0] opc;
   logic       zero;
   logic       mem_ready;
   logic       PCUpdate, IRWrite, RegWrite, MemWrite, AdrSrc, PCWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   logic       illegal, mem_err;

   int checks = 0;
   int errors = 0;

   // Expected output vectors per state, packed as
   // {PCUpdate, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
   localparam logic [12:0] V_FETCH    = 13'b1_1_0_0_0_10_00_10_00;
   localparam logic [12:0] V_DECODE   = 13'b0_0_0_0_0_00_01_01_00;
   localparam logic [12:0] V_MEMADR   = 13'b0_0_0_0_0_00_10_01_00;
   localparam logic [12:0] V_MEMREAD  = 13'b0_0_0_0_1_00_00_00_00;
   localparam logic [12:0] V_MEMWB    = 13'b0_0_1_0_0_01_00_00_00;
   localparam logic [12:0] V_MEMWRITE = 13'b0_0_0_1_1_00_00_00_00;
   localparam logic [12:0] V_MEMWSTL  = 13'b0_0_0_0_1_00_00_00_00;
   localparam logic [12:0] V_EXECR    = 13'b0_0_0_0_0_00_10_00_10;
   localparam logic [12:0] V_EXECI    = 13'b0_0_0_0_0_00_10_01_10;
   localparam logic [12:0] V_ALUWB    = 13'b0_0_1_0_0_00_00_00_00;
   localparam logic [12:0] V_BEQ      = 13'b0_0_0_0_0_00_10_00_01;
   localparam logic [12:0] V_JAL      = 13'b1_0_0_0_0_00_01_10_00;
   localparam logic [12:0] V_LUI      = 13'b0_0_1_0_0_11_00_00_00;
   localparam logic [12:0] V_FETCHSTL = 13'b0_0_0_0_0_10_00_10_00;

   multicycle_controller #(.MEM_TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .opc       (opc),
      .zero      (zero),
      .mem_ready (mem_ready),
      .PCUpdate  (PCUpdate),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .AdrSrc    (AdrSrc),
      .PCWrite   (PCWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .illegal   (illegal),
      .mem_err   (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] outs();
      return {PCUpdate, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
   endfunction

   task automatic test_reset();
      reset = 1'b1; opc = 7'b0110111; zero = 1'b0; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_FETCH || illegal !== 1'b0 || mem_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got outs=%b ill=%b err=%b, want outs=%b ill=0 err=0", outs(), illegal, mem_err, V_FETCH);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (outs() !== V_FETCH) begin
         errors++;
         $display("FAIL reset_release: got %b want %b", outs(), V_FETCH);
      end
   endtask

   task automatic test_lw();
      logic [12:0] exp [6];
      exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, V_FETCH};
      opc = 7'b0000011;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i] || illegal !== 1'b0) begin
            errors++;
            $display("FAIL lw_cycle%0d: got %b ill=%b want %b ill=0", i + 1, outs(), illegal, exp[i]);
         end
      end
      checks++;
      if (ImmSrc !== 3'b000) begin
         errors++;
         $display("FAIL lw_immsrc: got %b want 000", ImmSrc);
      end
   endtask

   task automatic test_sw();
      logic [12:0] exp [5];
      exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE, V_FETCH};
      opc = 7'b0100011;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i]) begin
            errors++;
            $display("FAIL sw_cycle%0d: got %b want %b", i + 1, outs(), exp[i]);
         end
      end
      checks++;
      if (ImmSrc !== 3'b001) begin
         errors++;
         $display("FAIL sw_immsrc: got %b want 001", ImmSrc);
      end
   endtask

   task automatic test_alu_ops();
      logic [12:0] exp_r [5];
      logic [12:0] exp_i [5];
      exp_r = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB, V_FETCH};
      exp_i = '{V_FETCH, V_DECODE, V_EXECI, V_ALUWB, V_FETCH};
      opc = 7'b0110011;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp_r[i]) begin
            errors++;
            $display("FAIL rtype_cycle%0d: got %b want %b", i + 1, outs(), exp_r[i]);
         end
      end
      opc = 7'b0010011;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp_i[i]) begin
            errors++;
            $display("FAIL itype_cycle%0d: got %b want %b", i + 1, outs(), exp_i[i]);
         end
      end
      checks++;
      if (ImmSrc !== 3'b000) begin
         errors++;
         $display("FAIL itype_immsrc: got %b want 000", ImmSrc);
      end
   endtask

   task automatic test_jal_lui();
      logic [12:0] exp_j [5];
      logic        pcw_j [5];
      logic [12:0] exp_u [4];
      exp_j = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB, V_FETCH};
      pcw_j = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_u = '{V_FETCH, V_DECODE, V_LUI, V_FETCH};
      opc = 7'b1101111;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp_j[i] || PCWrite !== pcw_j[i]) begin
            errors++;
            $display("FAIL jal_cycle%0d: got %b pcw=%b want %b pcw=%b", i + 1, outs(), PCWrite, exp_j[i], pcw_j[i]);
         end
      end
      checks++;
      if (ImmSrc !== 3'b011) begin
         errors++;
         $display("FAIL jal_immsrc: got %b want 011", ImmSrc);
      end
      opc = 7'b0110111;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp_u[i]) begin
            errors++;
            $display("FAIL lui_cycle%0d: got %b want %b", i + 1, outs(), exp_u[i]);
         end
      end
      checks++;
      if (ImmSrc !== 3'b100) begin
         errors++;
         $display("FAIL lui_immsrc: got %b want 100", ImmSrc);
      end
   endtask

   task automatic test_beq();
      logic [12:0] exp [4];
      logic        pcw1 [4];
      logic        pcw0 [4];
      exp  = '{V_FETCH, V_DECODE, V_BEQ, V_FETCH};
      pcw1 = '{1'b1, 1'b0, 1'b1, 1'b1};
      pcw0 = '{1'b1, 1'b0, 1'b0, 1'b1};
      opc = 7'b1100011;
      zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i] || PCWrite !== pcw1[i]) begin
            errors++;
            $display("FAIL beq_taken_cycle%0d: got %b pcw=%b want %b pcw=%b", i + 1, outs(), PCWrite, exp[i], pcw1[i]);
         end
      end
      checks++;
      if (ImmSrc !== 3'b010) begin
         errors++;
         $display("FAIL beq_immsrc: got %b want 010", ImmSrc);
      end
      zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i] || PCWrite !== pcw0[i]) begin
            errors++;
            $display("FAIL beq_not_taken_cycle%0d: got %b pcw=%b want %b pcw=%b", i + 1, outs(), PCWrite, exp[i], pcw0[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [12:0] exp [3];
      logic        ill [3];
      exp = '{V_FETCH, V_DECODE, V_FETCH};
      ill = '{1'b0, 1'b1, 1'b0};
      opc = 7'b1111111;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i] || illegal !== ill[i]) begin
            errors++;
            $display("FAIL illegal_cycle%0d: got %b ill=%b want %b ill=%b", i + 1, outs(), illegal, exp[i], ill[i]);
         end
      end
   endtask

   task automatic test_reset_mid_execute();
      opc = 7'b0110011;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_EXECR) begin
         errors++;
         $display("FAIL rst_mid_reach_exec: got %b want %b", outs(), V_EXECR);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_FETCH) begin
         errors++;
         $display("FAIL rst_mid_to_fetch: got %b want %b", outs(), V_FETCH);
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_DECODE) begin
         errors++;
         $display("FAIL rst_mid_no_aluwb: got %b want %b", outs(), V_DECODE);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_FETCH) begin
         errors++;
         $display("FAIL rst_mid_resume: got %b want %b", outs(), V_FETCH);
      end
   endtask

`ifdef MEM_WAIT_EN
   task automatic test_mem_wait();
      logic [12:0] exp [3];
      exp = '{V_FETCH, V_DECODE, V_MEMADR};
      opc = 7'b0100011;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i]) begin
            errors++;
            $display("FAIL wait_sw_cycle%0d: got %b want %b", i + 1, outs(), exp[i]);
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== V_MEMWSTL) begin
            errors++;
            $display("FAIL wait_sw_stall%0d: got %b want %b", i + 1, outs(), V_MEMWSTL);
         end
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (outs() !== V_MEMWRITE) begin
         errors++;
         $display("FAIL wait_sw_write: got %b want %b", outs(), V_MEMWRITE);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_FETCH) begin
         errors++;
         $display("FAIL wait_sw_done: got %b want %b", outs(), V_FETCH);
      end
   endtask

   task automatic test_mem_timeout();
      int pulses = 0;
      int first  = -1;
      int stall_bad = 0;
      opc = 7'b0110111;
      mem_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (mem_err === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (outs() !== V_FETCHSTL) stall_bad++;
      end
      checks++;
      if (pulses != 1 || first != 15) begin
         errors++;
         $display("FAIL timeout_pulse: got pulses=%0d at cycle %0d, want 1 at cycle 15", pulses, first);
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL timeout_stall_outs: got %0d bad cycles, want 0", stall_bad);
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (outs() !== V_FETCH || mem_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_refetch: got %b err=%b want %b err=0", outs(), mem_err, V_FETCH);
      end
      @(negedge clk);
      #1;
      checks++;
      if (outs() !== V_DECODE) begin
         errors++;
         $display("FAIL timeout_decode: got %b want %b", outs(), V_DECODE);
      end
      repeat (2) @(negedge clk);
      #1;
   endtask
`else
   task automatic test_ready_ignored();
      logic [12:0] exp [4];
      exp = '{V_FETCH, V_DECODE, V_LUI, V_FETCH};
      opc = 7'b0110111;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checks++;
         if (outs() !== exp[i] || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL ready_ignored_cycle%0d: got %b err=%b want %b err=0", i + 1, outs(), mem_err, exp[i]);
         end
      end
      mem_ready = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_alu_ops();
      test_jal_lui();
      test_beq();
      test_illegal();
      test_reset_mid_execute();
`ifdef MEM_WAIT_EN
      test_mem_wait();
      test_mem_timeout();
`else
      test_ready_ignored();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
